in_flight_issue_arbiter: RTL and testbench

//  Upstream issue stage for in_flight_tracker. Round-robin arbiter across COLORS request streams.

---
 rtl/in_flight_issue_arbiter.sv | 127 ++++++++++++
 tb/tb_in_flight_issue_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_flight_issue_arbiter.sv
// in_flight_issue_arbiter
// Round-robin issue stage in front of in_flight_tracker. Picks one request
// stream per cycle, offers its tag to the tracker, and on grant loads a
// one-entry registered output slot toward memory. A color whose tracker is
// full is skipped (pointer advances past it) so it cannot block other colors.
module in_flight_issue_arbiter #(
  parameter  int COLORS      = 4,
  parameter  int ADDR_WIDTH  = 48,
  localparam int LOG2_COLORS = $clog2(COLORS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [COLORS-1:0]            req_valid,
  input  logic [COLORS*ADDR_WIDTH-1:0] req_addr,
  output logic [COLORS-1:0]            req_ready,
  output logic [LOG2_COLORS-1:0]       trk_tag,
  input  logic                         trk_ready,
  output logic                         trk_push,
  output logic                         mem_valid,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [LOG2_COLORS-1:0]       mem_tag,
  input  logic                         mem_ready
);

  logic [LOG2_COLORS-1:0] rr_ptr_r;
  logic                   mem_valid_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic [LOG2_COLORS-1:0] mem_tag_r;

  logic                   has_cand_s;
  logic [LOG2_COLORS-1:0] cand_s;
  logic [LOG2_COLORS-1:0] cand_next_s;
  logic                   slot_free_s;
  logic                   grant_s;
  logic                   trk_stall_s;
  logic [ADDR_WIDTH-1:0]  sel_addr_s;

  // Candidate search: first valid stream starting at rr_ptr, wrapping modulo COLORS.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    logic [LOG2_COLORS-1:0] idx_v;
    idx_v      = rr_ptr_r;
    cand_s     = rr_ptr_r;
    has_cand_s = |req_valid;
    for (int i = COLORS - 1; i >= 0; i--) begin
      idx_v = rr_ptr_r + LOG2_COLORS'(i);
      if (req_valid[idx_v]) begin
        cand_s = idx_v;
      end else begin
        cand_s = cand_s;
      end
    end
  end

  // Tag offered to the tracker; depends only on req_valid and rr_ptr, never on ready inputs.
  always_comb begin
    if (has_cand_s) begin
      trk_tag = cand_s;
    end else begin
      trk_tag = rr_ptr_r;
    end
  end

  // Grant decision and handshake strobes, forced low while reset is asserted.
  always_comb begin
    slot_free_s = !mem_valid_r || mem_ready;
    grant_s     = rst_n && has_cand_s && trk_ready && slot_free_s;
    trk_stall_s = has_cand_s && !trk_ready;
    cand_next_s = cand_s + LOG2_COLORS'(1);
    trk_push    = grant_s;
    req_ready   = {COLORS{1'b0}};
    if (grant_s) begin
      req_ready[cand_s] = 1'b1;
    end else begin
      req_ready = {COLORS{1'b0}};
    end
  end

  // Address mux for the selected stream.
  always_comb begin
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < COLORS; i++) begin
      if (cand_s == LOG2_COLORS'(i)) begin
        sel_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Round-robin pointer: moves past the candidate on grant or tracker stall; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {LOG2_COLORS{1'b0}};
    end else if (grant_s || trk_stall_s) begin
      rr_ptr_r <= cand_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Output slot: load on grant (replacing a draining entry), clear on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_tag_r   <= {LOG2_COLORS{1'b0}};
    end else if (grant_s) begin
      mem_valid_r <= 1'b1;
      mem_addr_r  <= sel_addr_s;
      mem_tag_r   <= cand_s;
    end else if (mem_valid_r && mem_ready) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= mem_addr_r;
      mem_tag_r   <= mem_tag_r;
    end else begin
      mem_valid_r <= mem_valid_r;
      mem_addr_r  <= mem_addr_r;
      mem_tag_r   <= mem_tag_r;
    end
  end

  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_tag   = mem_tag_r;

endmodule

// File: tb/tb_in_flight_issue_arbiter.sv
// Self-checking bench for in_flight_issue_arbiter: directed vector table,
// hand-written stall/reset sequences, and a random soak against a queue-based model.
module tb_in_flight_issue_arbiter;
  localparam int COLORS = 4;
  localparam int AW     = 48;
  localparam int LC     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [COLORS-1:0] req_valid = '0;
  logic [COLORS*AW-1:0] req_addr;
  logic [COLORS-1:0] req_ready;
  logic [LC-1:0]     trk_tag;
  logic              trk_ready;
  logic              trk_push;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [LC-1:0]     mem_tag;
  logic              mem_ready = 1'b0;
  logic [COLORS-1:0] trk_mask = '1;
  logic [AW-1:0]     a [COLORS];

  // Tracker stand-in: ready is a per-tag lookup of the offered tag.
  assign trk_ready = trk_mask[trk_tag];

  // Pack per-stream addresses onto the flat bus.
  always_comb begin
    req_addr = '0;
    for (int i = 0; i < COLORS; i++) req_addr[i*AW +: AW] = a[i];
  end

  always #5 clk = ~clk;

  in_flight_issue_arbiter #(.COLORS(COLORS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .trk_tag(trk_tag), .trk_ready(trk_ready),
    .trk_push(trk_push), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_tag(mem_tag), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_rr;
  bit            m_mv;
  logic [AW-1:0] m_ma;
  int            m_mt;
  int            tag_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_push, n_hs;
  int            skip [COLORS];
  logic [COLORS-1:0] last_grant;

  typedef struct packed {
    logic [3:0] rv;
    logic [3:0] mask;
    logic       mr;
    logic [3:0] er;
    logic       ep;
    logic [1:0] et;
    logic       emv;
    logic [1:0] emt;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic int model_cand();
    for (int k = 0; k < COLORS; k++) begin
      if (req_valid[(m_rr + k) % COLORS]) return (m_rr + k) % COLORS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_mv = 0; m_ma = '0; m_mt = 0;
    tag_q.delete(); addr_q.delete();
    n_push = 0; n_hs = 0; last_grant = '0;
    for (int i = 0; i < COLORS; i++) skip[i] = 0;
  endtask

  // One cycle: called just after a rising edge with inputs already driven.
  task automatic step(output logic [COLORS-1:0] s_ready, output logic s_push,
                      output logic [LC-1:0] s_tag, output logic s_mv, output logic [LC-1:0] s_mt);
    int c; bit has; bit g; logic [COLORS-1:0] want_ready; bit mr;
    #2;
    c   = model_cand();
    has = (c >= 0);
    mr  = mem_ready;
    g   = has && trk_mask[c] && (!m_mv || mr);
    want_ready = '0;
    if (g) want_ready[c] = 1'b1;
    check("trk_tag",   trk_tag,   has ? c : m_rr);
    check("req_ready", req_ready, want_ready);
    check("trk_push",  trk_push,  g);
    check("mem_valid", mem_valid, m_mv);
    if (m_mv) begin
      check("mem_addr", mem_addr, m_ma);
      check("mem_tag",  mem_tag,  m_mt);
    end
    s_ready = req_ready; s_push = trk_push; s_tag = trk_tag; s_mv = mem_valid; s_mt = mem_tag;
    if (m_mv && mr) begin
      n_hs++;
      if (tag_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        check("sb_tag",  mem_tag,  tag_q[0]);
        check("sb_addr", mem_addr, addr_q[0]);
        void'(tag_q.pop_front());
        void'(addr_q.pop_front());
      end
    end
    if (g) begin
      n_push++;
      tag_q.push_back(c);
      addr_q.push_back(a[c]);
    end
    for (int i = 0; i < COLORS; i++) begin
      if (!req_valid[i] || c == i) skip[i] = 0;
      else if (g) begin
        skip[i]++;
        check("no_starve", skip[i] <= COLORS - 1, 1);
      end
    end
    last_grant = want_ready;
    @(posedge clk);
    if (g) begin
      m_mv = 1; m_ma = a[c]; m_mt = c; m_rr = (c + 1) % COLORS;
    end else begin
      if (m_mv && mr) m_mv = 0;
      if (has && !trk_mask[c]) m_rr = (c + 1) % COLORS;
    end
    #1;
  endtask

  initial begin
    logic [COLORS-1:0] sr; logic sp; logic [LC-1:0] st; logic smv; logic [LC-1:0] smt;

    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 2'd1};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 2'd2};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 2'd3};
    tbl[5]  = '{4'h3, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 2'd0};
    tbl[6]  = '{4'h8, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 2'd1};
    tbl[7]  = '{4'h3, 4'hE, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 2'd3};
    tbl[8]  = '{4'h3, 4'hE, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 2'd3};
    tbl[9]  = '{4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 2'd1};
    tbl[10] = '{4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 2'd0};
    tbl[11] = '{4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 2'd2};
    tbl[12] = '{4'h9, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 2'd3};
    tbl[13] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 2'd0};
    tbl[14] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1, 1'b0, 2'd0};

    for (int i = 0; i < COLORS; i++) a[i] = 48'hA5A5_0000_0000 + AW'(i) * 48'h1_0001;
    model_reset();

    // Reset state, with requests pending to show strobes are forced low.
    req_valid = 4'hF; trk_mask = 4'hF; mem_ready = 1'b1;
    #2;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_tag",   mem_tag,   0);
    check("rst_req_ready", req_ready, 0);
    check("rst_trk_push",  trk_push,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin, tracker skip, wrap: directed vector table.
    for (int k = 0; k < 15; k++) begin
      req_valid = tbl[k].rv; trk_mask = tbl[k].mask; mem_ready = tbl[k].mr;
      step(sr, sp, st, smv, smt);
      check("tbl_req_ready", sr,  tbl[k].er);
      check("tbl_trk_push",  sp,  tbl[k].ep);
      check("tbl_trk_tag",   st,  tbl[k].et);
      check("tbl_mem_valid", smv, tbl[k].emv);
      check("tbl_mem_tag",   smt, tbl[k].emt);
    end

    // Memory back-pressure: entry for stream 2 held for 5 cycles, then drain+grant.
    req_valid = 4'h4; trk_mask = 4'hF; mem_ready = 1'b1;
    step(sr, sp, st, smv, smt);
    check("bp_first_push", sp, 1);
    req_valid = 4'hF; mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(sr, sp, st, smv, smt);
      check("bp_no_push",  sp,       0);
      check("bp_held_tag", smt,      2);
      check("bp_held_adr", mem_addr, a[2]);
    end
    mem_ready = 1'b1;
    step(sr, sp, st, smv, smt);
    check("bp_drain_push",  sp,  1);
    check("bp_drain_valid", smv, 1);
    check("bp_drain_ready", sr,  4'h8);
    mem_ready = 1'b0;
    step(sr, sp, st, smv, smt);
    check("bp_new_tag", smt, 3);

    // Asynchronous reset mid-stall with an entry held.
    req_valid = 4'hF; mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_valid", mem_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_trk_push",  trk_push,  0);
    check("mid_rst_mem_addr",  mem_addr,  0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'h0; mem_ready = 1'b1;
    step(sr, sp, st, smv, smt);
    check("post_rst_rr_ptr", st, 0);

    // Random soak: requesters hold valid/addr until accepted.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < COLORS; i++) begin
        if (last_grant[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          a[i] = {16'($urandom), 32'($urandom)};
        end
      end
      for (int i = 0; i < COLORS; i++) trk_mask[i] = ($urandom_range(3, 0) != 0);
      mem_ready = ($urandom_range(9, 0) < 7);
      step(sr, sp, st, smv, smt);
    end
    check("push_vs_handshake", n_push, n_hs + int'(m_mv));
    check("sb_residual", tag_q.size(), int'(m_mv));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
